mw_pipe_reg: RTL

// - M->W pipeline register with a load-wait controller; sits between M-stage ALU/memory outputs and the W-stage writeback unit.
// - Issues word reads to the data memory and waits for dm_ack, stalling upstream via mem_busy.
// - Extracts and extends lb/lbu/lh/lhu/lw data, then presents PC4W/AOW/DRW/IRW to writeback.

---
 rtl/mw_pipe_reg.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg -- M->W pipeline register with a load-wait controller.
//
// Sits between the M-stage ALU/memory outputs and the W-stage writeback
// unit. Non-load instructions pass to W one cycle after they are presented.
// Loads issue a word read to data memory, stall upstream through mem_busy
// until dm_ack, then extract and extend the addressed byte/halfword/word.
// The W registers are rewritten every cycle, with a NOP (all zero) written
// whenever nothing retires.
//
// Optional feature: define MW_ACK_TIMEOUT_EN to abort a load that has not
// been acknowledged within TIMEOUT_CYCLES WAIT cycles (timeout_err pulses).
// Without the macro WAIT holds indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   PC4M/AOM/IRM in   M-stage PC+4, ALU result/address, instruction
//   M_valid      in   M stage holds a real instruction
//   flush        in   kill the M-stage instruction (W receives a NOP)
//   dm_req       out  registered read request
//   dm_addr      out  registered word address
//   dm_rdata     in   read data, valid with dm_ack
//   dm_ack       in   one-cycle read completion
//   mem_busy     out  combinational upstream stall
//   PC4W/AOW/DRW/IRW out  W-stage values (IRW=0 is a NOP)
//   W_valid      out  W holds a real instruction
//   timeout_err  out  one-cycle pulse on ack timeout
module mw_pipe_reg #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] IRM,
  input  logic        M_valid,
  input  logic        flush,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_busy,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW,
  output logic [31:0] IRW,
  output logic        W_valid,
  output logic        timeout_err
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mw_pipe_reg: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        dm_req_reg, dm_req_next;
  logic [31:0] dm_addr_reg, dm_addr_next;
  logic [1:0]  off_reg, off_next;       // byte offset of the pending load
  logic [5:0]  op_reg, op_next;         // opcode of the pending load
  logic [31:0] pc4w_reg, pc4w_next;
  logic [31:0] aow_reg, aow_next;
  logic [31:0] drw_reg, drw_next;
  logic [31:0] irw_reg, irw_next;
  logic        w_valid_reg, w_valid_next;
  logic        expire;
  logic        is_load;
  logic [31:0] load_data;
  logic [7:0]  rbyte [4];
  logic [15:0] rhalf;

  // ---------------------------------------------------------------------
  // Load decode and stall
  // ---------------------------------------------------------------------
  always_comb begin
    is_load = 1'b0;
    if (M_valid) begin
      case (IRM[31:26])
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
        default:                             is_load = 1'b0;
      endcase
    end
  end

  // The WAIT term deliberately ignores flush: the M stage is held until the
  // memory side has been resolved for this cycle.
  assign mem_busy = ((state_reg == ST_IDLE) && is_load && !flush) ||
                    ((state_reg == ST_WAIT) && !dm_ack);

  // ---------------------------------------------------------------------
  // Little-endian extraction of the returned word
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = dm_rdata[8*gi +: 8];
    end
  endgenerate

  assign rhalf = off_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    load_data = 32'h0;
    case (op_reg)
      OP_LB:   load_data = {{24{rbyte[off_reg][7]}}, rbyte[off_reg]};
      OP_LBU:  load_data = {24'h0, rbyte[off_reg]};
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'h0, rhalf};
      OP_LW:   load_data = dm_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional ack timeout
  // ---------------------------------------------------------------------
`ifdef MW_ACK_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_err_reg;

  // cnt_reg holds the number of ack-less WAIT cycles already elapsed, so the
  // cycle seeing CNT_LAST is the TIMEOUT_CYCLES-th one. Ack and flush both
  // take priority over expiry.
  assign expire = (state_reg == ST_WAIT) && !dm_ack && !flush &&
                  (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ST_IDLE) begin
      cnt_next = '0;
    end else if (!dm_ack && !expire) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      timeout_err_reg <= expire;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    dm_req_next  = dm_req_reg;
    dm_addr_next = dm_addr_reg;
    off_next     = off_reg;
    op_next      = op_reg;
    // W defaults to a NOP unless something retires this cycle.
    pc4w_next    = 32'h0;
    aow_next     = 32'h0;
    drw_next     = 32'h0;
    irw_next     = 32'h0;
    w_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!flush) begin
          if (is_load) begin
            dm_req_next  = 1'b1;
            dm_addr_next = {AOM[31:2], 2'b00};
            off_next     = AOM[1:0];
            op_next      = IRM[31:26];
            state_next   = ST_WAIT;
          end else if (M_valid) begin
            pc4w_next    = PC4M;
            aow_next     = AOM;
            irw_next     = IRM;
            w_valid_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          dm_req_next = 1'b0;
          state_next  = ST_IDLE;
        end else if (dm_ack) begin
          // M inputs are held stable by mem_busy, so they still describe
          // the load being completed.
          pc4w_next    = PC4M;
          aow_next     = AOM;
          irw_next     = IRM;
          drw_next     = load_data;
          w_valid_next = 1'b1;
          dm_req_next  = 1'b0;
          state_next   = ST_IDLE;
        end else if (expire) begin
          dm_req_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        dm_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      dm_req_reg  <= 1'b0;
      dm_addr_reg <= 32'h0;
      off_reg     <= 2'b00;
      op_reg      <= 6'h0;
      pc4w_reg    <= 32'h0;
      aow_reg     <= 32'h0;
      drw_reg     <= 32'h0;
      irw_reg     <= 32'h0;
      w_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dm_req_reg  <= dm_req_next;
      dm_addr_reg <= dm_addr_next;
      off_reg     <= off_next;
      op_reg      <= op_next;
      pc4w_reg    <= pc4w_next;
      aow_reg     <= aow_next;
      drw_reg     <= drw_next;
      irw_reg     <= irw_next;
      w_valid_reg <= w_valid_next;
    end
  end

  assign dm_req  = dm_req_reg;
  assign dm_addr = dm_addr_reg;
  assign PC4W    = pc4w_reg;
  assign AOW     = aow_reg;
  assign DRW     = drw_reg;
  assign IRW     = irw_reg;
  assign W_valid = w_valid_reg;

endmodule
